// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB and emits
// the per-state control strobes plus a retired-instruction counter.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        write_enable,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;
  logic        w_mem_op;
  logic        w_wb_op;

  assign w_mem_op = mem_read | mem_write;
  assign w_wb_op  = write_enable | jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      BOOT:    w_next = FETCH;
      FETCH:   w_next = imem_ready ? DECODE : FETCH;
      DECODE:  w_next = EXEC;
      EXEC: begin
        if (w_mem_op)     w_next = MEM;
        else if (w_wb_op) w_next = WB;
        else              w_next = FETCH;
      end
      MEM: begin
        if (!dmem_ready)   w_next = MEM;
        else if (mem_read) w_next = WB;
        else               w_next = FETCH;
      end
      WB:      w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  // Strobes depend on the current state and live inputs only; the unused
  // codes 6/7 fall into the default arm and keep everything low.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      EXEC: begin
        if (!w_mem_op && !w_wb_op) begin
          pc_we  = 1'b1;
          pc_sel = jump | (branch & br_taken);
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write & ~mem_read;
        if (dmem_ready && !mem_read) begin
          pc_we  = 1'b1;
          pc_sel = 1'b0;
        end
      end
      WB: begin
        rf_we  = write_enable;
        pc_we  = 1'b1;
        pc_sel = jump;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (pc_we) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks R-type, JAL, load, store, branch
// and mid-MEM reset sequences against hand-computed state/strobe vectors.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch;
  logic        jump;
  logic        mem_read;
  logic        mem_write;
  logic        write_enable;
  logic        br_taken;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int unsigned checks;
  int unsigned errors;

  instr_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch       (branch),
    .jump         (jump),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .write_enable (write_enable),
    .br_taken     (br_taken),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .state        (state),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector layout: {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}
  task automatic chk_o(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    #1;
    obs = {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [31:0] exp);
    checks++;
    assert (instret === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instret, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    branch = 1'b0; jump = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    write_enable = 1'b0; br_taken = 1'b0;
    #2;
    chk_o("reset_outputs", {3'd0, 7'b0000000});
    chk_i("reset_instret", 32'd0);

    // Release right after an edge so BOOT occupies one whole cycle; readies are ignored there
    tick();
    rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; write_enable = 1'b1;
    chk_o("boot", {3'd0, 7'b0000000});

    // R-type, zero-wait memory
    tick(); chk_o("rtype_fetch",  {3'd1, 7'b1100000});
    tick(); chk_o("rtype_decode", {3'd2, 7'b0000000});
    tick(); chk_o("rtype_exec",   {3'd3, 7'b0000000});
    tick(); chk_o("rtype_wb",     {3'd5, 7'b0000110});
    chk_i("rtype_instret_before", 32'd0);
    tick(); imem_ready = 1'b0; jump = 1'b1; dmem_ready = 1'b0;
    chk_o("rtype_next_fetch", {3'd1, 7'b1000000});
    chk_i("rtype_instret_after", 32'd1);

    // JAL with imem_ready held off four cycles
    tick(); chk_o("jal_wait2", {3'd1, 7'b1000000});
    tick(); chk_o("jal_wait3", {3'd1, 7'b1000000});
    tick(); chk_o("jal_wait4", {3'd1, 7'b1000000});
    tick(); imem_ready = 1'b1;
    chk_o("jal_fetch5", {3'd1, 7'b1100000});
    tick(); imem_ready = 1'b0;
    chk_o("jal_decode", {3'd2, 7'b0000000});
    tick(); chk_o("jal_exec", {3'd3, 7'b0000000});
    tick(); chk_o("jal_wb",   {3'd5, 7'b0000111});
    tick(); chk_i("jal_instret", 32'd2);

    // Load with dmem_ready low for two MEM cycles
    imem_ready = 1'b1; jump = 1'b0; mem_read = 1'b1; write_enable = 1'b1;
    chk_o("ld_fetch", {3'd1, 7'b1100000});
    tick(); imem_ready = 1'b0;
    chk_o("ld_decode", {3'd2, 7'b0000000});
    tick(); chk_o("ld_exec",  {3'd3, 7'b0000000});
    tick(); chk_o("ld_mem1",  {3'd4, 7'b0010000});
    tick(); chk_o("ld_mem2",  {3'd4, 7'b0010000});
    tick(); dmem_ready = 1'b1;
    chk_o("ld_mem3", {3'd4, 7'b0010000});
    tick(); dmem_ready = 1'b0;
    chk_o("ld_wb", {3'd5, 7'b0000110});
    tick(); chk_i("ld_instret", 32'd3);

    // Store, immediate dmem_ready
    imem_ready = 1'b1; mem_read = 1'b0; mem_write = 1'b1; write_enable = 1'b0;
    dmem_ready = 1'b1;
    chk_o("st_fetch", {3'd1, 7'b1100000});
    tick(); imem_ready = 1'b0;
    chk_o("st_decode", {3'd2, 7'b0000000});
    tick(); chk_o("st_exec", {3'd3, 7'b0000000});
    tick(); chk_o("st_mem",  {3'd4, 7'b0011010});
    tick(); chk_o("st_next_fetch", {3'd1, 7'b1000000});
    chk_i("st_instret", 32'd4);

    // Branch taken, then not taken
    imem_ready = 1'b1; mem_write = 1'b0; branch = 1'b1; br_taken = 1'b1;
    tick(); imem_ready = 1'b0;
    chk_o("bt_decode", {3'd2, 7'b0000000});
    tick(); chk_o("bt_exec", {3'd3, 7'b0000011});
    tick(); imem_ready = 1'b1; br_taken = 1'b0;
    chk_o("bt_next_fetch", {3'd1, 7'b1100000});
    chk_i("bt_instret", 32'd5);
    tick(); imem_ready = 1'b0;
    chk_o("bn_decode", {3'd2, 7'b0000000});
    tick(); chk_o("bn_exec", {3'd3, 7'b0000010});
    tick(); chk_o("bn_next_fetch", {3'd1, 7'b1000000});
    chk_i("bn_instret", 32'd6);

    // Load stalled in MEM, then asynchronous reset mid-request
    imem_ready = 1'b1; branch = 1'b0; mem_read = 1'b1; write_enable = 1'b1;
    dmem_ready = 1'b0;
    tick(); imem_ready = 1'b0;
    tick(); chk_o("rst_exec", {3'd3, 7'b0000000});
    tick(); chk_o("rst_mem",  {3'd4, 7'b0010000});
    rst_n = 1'b0;
    chk_o("rst_async_outputs", {3'd0, 7'b0000000});
    chk_i("rst_async_instret", 32'd0);
    tick(); rst_n = 1'b1;
    chk_o("rst_boot", {3'd0, 7'b0000000});
    tick(); chk_o("rst_first_fetch", {3'd1, 7'b1000000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
